// File: rtl/apb_cmd_pkg.sv
// Shared types for the fill-command executor: FSM state and status encodings.
package apb_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } cmdStateT;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;
  localparam logic [1:0] ST_ERR  = 2'b11;

endpackage

// File: rtl/apb_cmd_watchdog.sv
// Stall watchdog: counts cycles with en high, flags expire on the last allowed cycle.
module apb_cmd_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] timer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (clr) begin
      timer <= '0;
    end else if (en) begin
      timer <= timer + TW'(1);
    end
  end

  // Combinational so the FSM can leave WRITE on the same edge the limit is hit.
  assign expire = en && (timer == TW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_cmd_executor.sv
// Fill-command executor: writes ilen words starting at iaddr/idata over a valid/ready port.
module apb_cmd_executor
  import apb_cmd_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8,
  parameter int ADDR_STEP = 4,
  parameter int INC_DATA  = 1,
  parameter int TIMEOUT   = 1024
) (
  input  logic              io_systemClk,
  input  logic              io_systemReset,
  input  logic              start,
  input  logic [ADDR_W-1:0] iaddr,
  input  logic [DATA_W-1:0] idata,
  input  logic [LEN_W-1:0]  ilen,
  output logic [1:0]        status,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done_irq
);

  cmdStateT         state;
  logic             startQ;
  logic             startRise;
  logic             accept;
  logic             xfer;
  logic             lastWord;
  logic             expire;
  logic [LEN_W-1:0] lenReg;
  logic [LEN_W-1:0] cnt;

  assign startRise = start & ~startQ;
  // A rising start while a command runs is dropped, not queued.
  assign accept    = startRise && (state != WRITE);
  assign xfer      = (state == WRITE) && mem_valid && mem_ready;
  assign lastWord  = (cnt == lenReg - LEN_W'(1));

  apb_cmd_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) uWatchdog (
    .clk   (io_systemClk),
    .rst   (io_systemReset),
    .clr   (accept | xfer),
    .en    (mem_valid & ~mem_ready),
    .expire(expire)
  );

  always_ff @(posedge io_systemClk or posedge io_systemReset) begin
    if (io_systemReset) begin
      state     <= IDLE;
      startQ    <= 1'b0;
      lenReg    <= '0;
      cnt       <= '0;
      status    <= ST_IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done_irq  <= 1'b0;
    end else begin
      startQ   <= start;
      done_irq <= 1'b0;
      case (state)
        WRITE: begin
          // A ready on the expiry cycle takes priority: the word counts, no error.
          if (xfer) begin
            cnt       <= cnt + LEN_W'(1);
            mem_addr  <= mem_addr + ADDR_W'(ADDR_STEP);
            mem_wdata <= mem_wdata + DATA_W'(INC_DATA);
            if (lastWord) begin
              state     <= DONE;
              mem_valid <= 1'b0;
              status    <= ST_DONE;
              done_irq  <= 1'b1;
            end
          end else if (expire) begin
            state     <= ERROR;
            mem_valid <= 1'b0;
            status    <= ST_ERR;
            done_irq  <= 1'b1;
          end
        end
        default: begin
          // IDLE, DONE and ERROR all accept a new command directly.
          if (startRise) begin
            lenReg    <= ilen;
            mem_addr  <= iaddr;
            mem_wdata <= idata;
            cnt       <= '0;
            if (ilen != '0) begin
              state     <= WRITE;
              mem_valid <= 1'b1;
              status    <= ST_BUSY;
            end else begin
              state     <= DONE;
              status    <= ST_DONE;
              done_irq  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_executor.sv
// Randomized self-checking bench: predicts each word, stall timeout and completion from the command alone.
module tb_apb_cmd_executor;
  import apb_cmd_pkg::*;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] iaddr = '0;
  logic [31:0] idata = '0;
  logic [7:0]  ilen = '0;
  logic [1:0]  status;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        done_irq;

  int nCompared = 0;
  int nMismatched = 0;

  apb_cmd_executor #(
    .ADDR_W(32), .DATA_W(32), .LEN_W(8), .ADDR_STEP(4), .INC_DATA(1), .TIMEOUT(TMO)
  ) dut (
    .io_systemClk  (clk),
    .io_systemReset(rst),
    .start         (start),
    .iaddr         (iaddr),
    .idata         (idata),
    .ilen          (ilen),
    .status        (status),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .done_irq      (done_irq)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // readyMode: 0..100 = percent chance of ready per cycle, -1 = ready one cycle in three.
  // midStart: cycle index at which a second start pulse is issued (0 = none).
  task automatic runCmd(input logic [31:0] a, input logic [31:0] d, input logic [7:0] n,
                        input int readyMode, input int midStart);
    int k, stall, cyc;
    bit expDone, expErr, fin, rdy;
    logic [31:0] ea, ed;
    $display("cmd addr=%h data=%h len=%0d ready=%0d midstart=%0d", a, d, n, readyMode, midStart);
    @(negedge clk);
    iaddr = a; idata = d; ilen = n; start = 1'b1; mem_ready = 1'b0;
    k = 0; stall = 0; cyc = 0; expErr = 1'b0; fin = 1'b0;
    expDone = (n == 8'd0);
    while (!fin) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        iaddr = 32'($urandom); idata = 32'($urandom); ilen = 8'($urandom);
      end
      if (midStart != 0 && cyc == midStart) start = 1'b1;
      if (midStart != 0 && cyc == midStart + 1) start = 1'b0;
      checkVal("done_irq", done_irq, expDone);
      if (done_irq !== expDone) begin
        fin = 1'b1;
      end else if (expDone) begin
        checkVal("status_end", status, expErr ? ST_ERR : ST_DONE);
        checkVal("valid_end", mem_valid, 1'b0);
        fin = 1'b1;
      end else begin
        checkVal("valid", mem_valid, 1'b1);
        checkVal("status_busy", status, ST_BUSY);
        ea = a + 32'(4 * k);
        ed = d + 32'(k);
        checkVal("addr", mem_addr, ea);
        checkVal("data", mem_wdata, ed);
        if (readyMode < 0) rdy = (cyc % 3 == 0);
        else rdy = ($urandom_range(99) < readyMode);
        mem_ready = rdy;
        if (rdy) begin
          k++; stall = 0;
          if (k == int'(n)) expDone = 1'b1;
        end else begin
          stall++;
          if (stall == TMO) begin expDone = 1'b1; expErr = 1'b1; end
        end
      end
      if (cyc > 400) begin
        checkVal("cycle_budget", 64'(cyc), 64'd400);
        fin = 1'b1;
      end
    end
    start = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    checkVal("irq_once", done_irq, 1'b0);
    checkVal("valid_after", mem_valid, 1'b0);
    checkVal("status_sticky", status, expErr ? ST_ERR : ST_DONE);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkVal("rst_status", status, ST_IDLE);
    checkVal("rst_valid", mem_valid, 1'b0);
    checkVal("rst_irq", done_irq, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkVal("idle_status", status, ST_IDLE);

    runCmd(32'h1000, 32'hA5, 8'd4, 100, 0);
    runCmd(32'h1000, 32'hA5, 8'd4, -1, 0);
    runCmd(32'h5000, 32'h77, 8'd2, 0, 0);
    runCmd(32'h6000, 32'h11, 8'd0, 100, 0);
    runCmd(32'h7000, 32'h20, 8'd10, 100, 3);
    runCmd(32'h7100, 32'h30, 8'd5, 100, 5);
    runCmd(32'hFFFF_FFFC, 32'hFFFF_FFFF, 8'd2, 100, 0);

    // Reset part-way through an 8-word command.
    $display("cmd addr=00002000 data=00000001 len=8 reset-after-3");
    @(negedge clk);
    iaddr = 32'h2000; idata = 32'h1; ilen = 8'd8; start = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("pre_rst_addr", mem_addr, 32'h200C);
    #2 rst = 1'b1;
    #1;
    checkVal("async_valid", mem_valid, 1'b0);
    checkVal("async_status", status, ST_IDLE);
    checkVal("async_irq", done_irq, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkVal("post_rst_valid", mem_valid, 1'b0);
      checkVal("post_rst_status", status, ST_IDLE);
    end
    mem_ready = 1'b0;
    runCmd(32'h3000, 32'h10, 8'd3, 100, 0);

    for (int r = 0; r < 10; r++) begin
      int modes[4] = '{100, 33, 50, 80};
      runCmd(32'($urandom), 32'($urandom), 8'($urandom_range(0, 12)),
             modes[$urandom_range(0, 3)], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
